// File: rtl/mean_seq_if.sv
// Handshake and accumulator-link bundle for the block-mean controller.
// The slave modport is the controller's view; master is the environment's view.
interface mean_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              acc_clr;
    logic              acc_en;
    logic [DATA_W-1:0] acc_x;
    logic [DATA_W-1:0] acc_y;
    logic              busy;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_mean;
    logic [DATA_W-1:0] m_rem;

    modport slave (
        input  start, s_valid, s_data, acc_y, m_ready,
        output s_ready, acc_clr, acc_en, acc_x, busy, m_valid, m_mean, m_rem
    );

    modport master (
        output start, s_valid, s_data, acc_y, m_ready,
        input  s_ready, acc_clr, acc_en, acc_x, busy, m_valid, m_mean, m_rem
    );
endinterface

// File: rtl/mean_seq.sv
// Block-mean sequencer: clears the external accumulator, feeds it N stream samples,
// then divides the sum by N with a bit-serial restoring divider.
module mean_seq #(
    parameter int DATA_W = 32,
    parameter int N      = 100,
    parameter int CNT_W  = 8
) (
    input  logic      clk,
    input  logic      rst,
    mean_seq_if.slave bus
);
    localparam int                ITER_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W:0]   N_EXT     = (DATA_W + 1)'(N);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_SETTLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ITER_W-1:0] r_iter;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W:0]   r_rem;
    logic              w_accept;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_fits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        bus.s_ready  = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_x    = '0;
        bus.m_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.acc_clr  = 1'b1;
                w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_accept   = 1'b1;
                    bus.acc_en = 1'b1;
                    bus.acc_x  = bus.s_data;
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                w_state_next = S_DIV;
            end
            S_DIV: begin
                if (r_iter == ITER_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.m_mean = r_quot;
    assign bus.m_rem  = r_rem[DATA_W-1:0];

    // One restoring step: bring down the next dividend bit, subtract N if it fits.
    // r_quot doubles as the dividend shifter; quotient bits fill in from the LSB.
    assign w_shift = (r_rem << 1) | {{DATA_W{1'b0}}, r_quot[DATA_W-1]};
    assign w_fits  = (w_shift >= N_EXT);
    assign w_diff  = w_shift - N_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_iter <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= '0;
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    r_quot <= bus.acc_y;
                    r_rem  <= '0;
                    r_iter <= '0;
                end
                S_DIV: begin
                    r_rem  <= w_fits ? w_diff : w_shift;
                    r_quot <= {r_quot[DATA_W-2:0], w_fits};
                    r_iter <= r_iter + ITER_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mean_seq.sv
// Scoreboard bench for mean_seq: stimulus pushes expected (mean, rem) pairs,
// monitors pop and compare on each output transfer.
module tb_mean_seq;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] mean;
        logic [DW-1:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mean_seq_if #(.DATA_W(DW)) bus_a ();
    mean_seq_if #(.DATA_W(DW)) bus_b ();

    mean_seq #(.DATA_W(DW), .N(100), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mean_seq #(.DATA_W(DW), .N(3),   .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // External accumulators with the clr/en/x/y contract, wrapping modulo 2^DW
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                bus_a.acc_y <= '0;
        else if (bus_a.acc_clr) bus_a.acc_y <= '0;
        else if (bus_a.acc_en)  bus_a.acc_y <= bus_a.acc_y + bus_a.acc_x;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                bus_b.acc_y <= '0;
        else if (bus_b.acc_clr) bus_b.acc_y <= '0;
        else if (bus_b.acc_en)  bus_b.acc_y <= bus_b.acc_y + bus_b.acc_x;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t          exp_q_a[$];
    exp_t          exp_q_b[$];
    logic [DW-1:0] smp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  en_cnt_a = 0;
    int  clr_cnt_a = 0;
    int  bad_x    = 0;
    int  rise_cyc_a = 0;
    int  e0_cyc   = 0;
    bit  prev_xfer_a = 1'b0;
    bit  prev_v_a    = 1'b0;
    bit  prev_xfer_b = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event, required normal progress", name);
    endtask

    // Monitor A: scoreboard pop on transfer, one-cycle valid, strobe bookkeeping
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (prev_xfer_a) check("a_valid_drop", bus_a.m_valid, 1'b0);
            prev_xfer_a = 1'b0;
            if (bus_a.m_valid && !prev_v_a) rise_cyc_a = cyc;
            prev_v_a = bus_a.m_valid;
            if (bus_a.m_valid && bus_a.m_ready) begin
                if (exp_q_a.size() == 0) begin
                    fail_now("a_unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q_a.pop_front();
                    check("a_mean", bus_a.m_mean, e.mean);
                    check("a_rem", bus_a.m_rem, e.rem);
                    $display("A result mean=%0d rem=%0d (expected %0d/%0d)",
                             bus_a.m_mean, bus_a.m_rem, e.mean, e.rem);
                    prev_xfer_a = 1'b1;
                end
            end
            if (bus_a.acc_en)  en_cnt_a++;
            if (bus_a.acc_clr) clr_cnt_a++;
            if (bus_a.acc_en !== (bus_a.s_valid && bus_a.s_ready)) bad_x++;
            if (bus_a.acc_x !== (bus_a.acc_en ? bus_a.s_data : {DW{1'b0}})) bad_x++;
        end else begin
            prev_xfer_a = 1'b0;
            prev_v_a    = 1'b0;
        end
    end

    // Monitor B (N=3 instance)
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (prev_xfer_b) check("b_valid_drop", bus_b.m_valid, 1'b0);
            prev_xfer_b = 1'b0;
            if (bus_b.m_valid && bus_b.m_ready) begin
                if (exp_q_b.size() == 0) begin
                    fail_now("b_unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q_b.pop_front();
                    check("b_mean", bus_b.m_mean, e.mean);
                    check("b_rem", bus_b.m_rem, e.rem);
                    $display("B result mean=%0d rem=%0d (expected %0d/%0d)",
                             bus_b.m_mean, bus_b.m_rem, e.mean, e.rem);
                    prev_xfer_b = 1'b1;
                end
            end
        end else begin
            prev_xfer_b = 1'b0;
        end
    end

    task automatic push_lit_a(input logic [DW-1:0] m, input logic [DW-1:0] r);
        exp_t e;
        e.mean = m;
        e.rem  = r;
        exp_q_a.push_back(e);
    endtask

    // Reference model: wrapping sum of the block, then plain divide and modulo
    task automatic push_model_a();
        logic [DW-1:0] s;
        s = '0;
        foreach (smp_q[i]) s = s + smp_q[i];
        push_lit_a(s / 32'd100, s % 32'd100);
    endtask

    task automatic start_a();
        int t;
        t = 0;
        @(negedge clk);
        while (bus_a.busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (bus_a.busy) fail_now("a_idle_timeout");
        en_cnt_a     = 0;
        clr_cnt_a    = 0;
        bus_a.start  = 1'b1;
        e0_cyc       = cyc + 1;
        @(negedge clk);
        bus_a.start  = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 random idle cycles, 2 idle cycle between samples
    task automatic feed_a(input int gap_mode);
        int t;
        for (int i = 0; i < smp_q.size(); i++) begin
            if ((gap_mode == 1 && $urandom_range(0, 1) == 1) || (gap_mode == 2 && i > 0)) begin
                bus_a.s_valid = 1'b0;
                bus_a.s_data  = $urandom;
                @(negedge clk);
            end
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = smp_q[i];
            t = 0;
            while (!bus_a.s_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!bus_a.s_ready) begin
                fail_now("a_feed_timeout");
                break;
            end
            @(negedge clk);
        end
        bus_a.s_valid = 1'b0;
        bus_a.s_data  = '0;
    endtask

    task automatic wait_done_a(input bit rnd_ready);
        int t;
        t = 0;
        while (exp_q_a.size() != 0 && t < 2000) begin
            @(negedge clk);
            if (rnd_ready) bus_a.m_ready = 1'($urandom_range(0, 1));
            t++;
        end
        if (exp_q_a.size() != 0) begin
            fail_now("a_result_timeout");
            exp_q_a.delete();
        end
        bus_a.m_ready = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] cap_mean;
        logic [DW-1:0] cap_rem;
        int t;
        logic [DW-1:0] b_vals[3];

        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.m_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus_a.s_ready, bus_a.acc_clr, bus_a.acc_en, bus_a.busy, bus_a.m_valid}, 5'b0);
        check("rst_acc_x", bus_a.acc_x, 32'd0);
        check("rst_mean", bus_a.m_mean, 32'd0);
        check("rst_rem", bus_a.m_rem, 32'd0);
        rst = 1'b0;

        // Ramp 0..99, continuous, latency from start edge
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back(DW'(i));
        push_lit_a(32'd49, 32'd50);
        start_a();
        feed_a(0);
        wait_done_a(1'b0);
        check("t1_latency", rise_cyc_a - e0_cyc, 134);
        check("t1_en_pulses", en_cnt_a, 100);
        check("t1_clr_pulses", clr_cnt_a, 1);

        // Constant 20 with s_valid toggling
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back(32'd20);
        push_lit_a(32'd20, 32'd0);
        start_a();
        feed_a(2);
        wait_done_a(1'b0);
        check("t2_en_pulses", en_cnt_a, 100);
        check("t2_clr_pulses", clr_cnt_a, 1);

        // All-ones samples: accumulator wraps
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back(32'hFFFF_FFFF);
        push_lit_a(32'h028F_5C27, 32'd96);
        start_a();
        feed_a(0);
        wait_done_a(1'b0);

        // Back-pressure in DONE with start pulses that must be ignored
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back($urandom);
        push_model_a();
        bus_a.m_ready = 1'b0;
        start_a();
        feed_a(1);
        t = 0;
        while (!bus_a.m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus_a.m_valid) fail_now("t4_valid_timeout");
        cap_mean = bus_a.m_mean;
        cap_rem  = bus_a.m_rem;
        for (int k = 0; k < 10; k++) begin
            bus_a.start = (k % 2 == 0);
            @(negedge clk);
            #2;
            check("t4_hold", {bus_a.m_valid, bus_a.m_mean, bus_a.m_rem}, {1'b1, cap_mean, cap_rem});
        end
        @(negedge clk);
        bus_a.start   = 1'b0;
        bus_a.m_ready = 1'b1;
        @(negedge clk);
        #2;
        check("t4_idle_after_xfer", bus_a.busy, 1'b0);
        @(negedge clk);
        #2;
        check("t4_no_clear", clr_cnt_a, 1);
        wait_done_a(1'b0);

        // Randomized blocks with gaps and random m_ready
        for (int b = 0; b < 4; b++) begin
            smp_q.delete();
            for (int i = 0; i < 100; i++)
                smp_q.push_back((b % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1000)));
            push_model_a();
            start_a();
            feed_a(1);
            wait_done_a(1'b1);
        end

        // Reset mid-division, then a fresh block of sevens
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back($urandom);
        start_a();
        feed_a(0);
        repeat (10) @(negedge clk);
        check("t5_busy_in_div", bus_a.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_ctrl", {bus_a.s_ready, bus_a.acc_clr, bus_a.acc_en, bus_a.busy, bus_a.m_valid}, 5'b0);
        check("t5_rst_acc_x", bus_a.acc_x, 32'd0);
        check("t5_rst_mean", bus_a.m_mean, 32'd0);
        check("t5_rst_rem", bus_a.m_rem, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        smp_q.delete();
        for (int i = 0; i < 100; i++) smp_q.push_back(32'd7);
        push_lit_a(32'd7, 32'd0);
        start_a();
        feed_a(0);
        wait_done_a(1'b0);

        // N=3 instance: 5,6,8 -> 19 = 6*3 + 1
        b_vals[0] = 32'd5;
        b_vals[1] = 32'd6;
        b_vals[2] = 32'd8;
        begin
            exp_t e;
            e.mean = 32'd6;
            e.rem  = 32'd1;
            exp_q_b.push_back(e);
        end
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_b.s_valid = 1'b1;
            bus_b.s_data  = b_vals[i];
            t = 0;
            while (!bus_b.s_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!bus_b.s_ready) fail_now("b_feed_timeout");
            @(negedge clk);
        end
        #1;
        check("b_sready_after_last", bus_b.s_ready, 1'b0);
        bus_b.s_valid = 1'b0;
        t = 0;
        while (exp_q_b.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q_b.size() != 0) fail_now("b_result_timeout");
        repeat (2) @(negedge clk);

        check("acc_x_en_consistency", bad_x, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
